bot_io_hub: RTL
===============

Name: bot_io_hub

Overview:
Parametrised PicoBlaze I/O register hub for the Rojobot/Nexys4 system. It generalises the bot interface in several ways:
- configurable counts of switch banks, LED banks and 7-segment digits
- a coherent snapshot of the bot registers
- a maskable, multi-source interrupt controller with pending/clear registers
- deterministic reads (unmapped ports return 0)

It sits between the KCPSM6 port bus and the board I/O / bot model.

Parameters:
NUM_SW_BANKS, 2, number of 8-bit switch banks (1..4)
NUM_LED_BANKS, 2, number of 8-bit LED banks (1..4)
NUM_DIGITS, 8, number of 5-bit 7-segment digit codes (1..8)
FULL_DECODE, 0, 1: port_id[7:5] must be 0 for a hit; 0: port_id[7:5] ignored

Ports:
sysclk  in  1  system clock
sysreset  in  1  asynchronous, active-high reset
port_id  in  8  KCPSM6 port address
io_data_in  in  8  write data
write_strobe  in  1  INPUT/OUTPUT write qualifier
k_write_strobe  in  1  OUTPUTK write qualifier (decodes port_id[3:0] only)
read_strobe  in  1  read qualifier (informational; reads have no side effects)
io_data_out  out  8  registered read data
interrupt  out  1  interrupt request to KCPSM6
interrupt_ack  in  1  interrupt acknowledge pulse
dbbtns  in  5  debounced buttons
sw  in  8*NUM_SW_BANKS  switches
irq_ext  in  1  external interrupt source, level, sampled for rising edge
locx, locy, botinfo, sensors, lmdist, rmdist  in  8 each  bot model registers
upd_sysregs  in  1  one-cycle bot update pulse
MotCtl  out  8  motor control
leds  out  8*NUM_LED_BANKS  LED banks
digits  out  5*NUM_DIGITS  digit codes, digit i at [5i+4:5i]
dp  out  NUM_DIGITS  decimal points

Behaviour:
- Decode uses port_id[4:0]. The address map is:
  - 0x00 BTN (RO, zero-extended)
  - 0x01 IRQ_PEND (RO)
  - 0x02 IRQ_MASK (RW, bits[3:0])
  - 0x03 IRQ_CLR (WO, write-1-to-clear)
  - 0x04 MotCtl (RW)
  - 0x05 DP (RW, bits[NUM_DIGITS-1:0])
  - 0x08..0x0D snapshot locx, locy, botinfo, sensors, lmdist, rmdist (RO)
  - 0x10+i SW bank i (RO)
  - 0x14+i LED bank i (RW)
  - 0x18+i digit i (RW, bits[4:0])
- Indices beyond their parameter count, and all other addresses, are unmapped: reads return 0x00 and writes are ignored. Unused bits of any register read back as 0.
- Read latency: io_data_out is registered every cycle from the current port_id; it is valid on the next sysclk edge.
- Writes: on write_strobe=1 the addressed RW register takes io_data_in at the clock edge.
- k_write_strobe=1 uses address {1'b0, port_id[3:0]}. It reaches only 0x00..0x0F; OUTPUTK cannot reach 0x10..0x1F.
- Writes to RO addresses have no effect.
- Snapshot: the six bot registers are captured into shadow registers in the cycle upd_sysregs=1. Reads always return the shadow values, so a multi-port read sequence between updates is coherent.
- IRQ sources (pending bit):
  - 0 = upd_sysregs
  - 1 = any dbbtns bit rising edge (previous-cycle register)
  - 2 = any sw bit change vs previous cycle
  - 3 = irq_ext rising edge
- Pending bits set on an event regardless of mask. A write to IRQ_CLR clears the bits where io_data_in=1.
- A set event and a clear of the same bit in the same cycle: set wins.
- Interrupt handshake uses an in_service flag:
  - interrupt register <= 1 when (pend & mask) != 0 and in_service=0.
  - interrupt_ack=1 drives interrupt <= 0 and in_service <= 1.
  - Any write to IRQ_CLR clears in_service; interrupt may re-assert the following cycle if any pend & mask bit remains.
- Reset (async): io_data_out, interrupt, MotCtl, leds, digits, dp, mask, pend, in_service, snapshot and edge-history registers all go to 0.
  - Edge history resets to 0, so buttons or switches held high through reset raise pend[1]/pend[2] in the first cycle after release.
  - Reset asserted mid-handshake drops interrupt immediately.

Decomposition:
- bot_io_pkg holds the address constants (ADDR_BTN, ADDR_IRQ_PEND, ADDR_IRQ_MASK, ADDR_IRQ_CLR, ADDR_MOTCTL, ADDR_DP, ADDR_BOT_BASE, ADDR_SW_BASE, ADDR_LED_BASE, ADDR_DIG_BASE) and the IRQ bit indices (IRQ_UPD, IRQ_BTN, IRQ_SW, IRQ_EXT).
- Sub-module bot_irq_ctrl owns edge detection, pend/mask/in_service and interrupt generation; the top level owns decode, registers and snapshot.

Test Plan:
- Reset then write 0x5A to port 0x14, then read port 0x14: io_data_out=0x5A one cycle after port_id; leds[7:0]=0x5A. Read 0x17 with NUM_LED_BANKS=2: returns 0x00.
- k_write_strobe, port_id=0x1A, data 0x33: writes 0x0A (MotCtl unaffected, 0x0A unmapped) and no digit changes; with write_strobe, port_id=0x1A, data 0x1F: digits[14:10]=0x1F.
- locx=0x10 with upd_sysregs pulse, then locx=0x20 without pulse; read 0x08: returns 0x10. Next pulse: returns 0x20.
- mask=0x01, upd_sysregs pulse: interrupt=1 next cycle. Ack: interrupt=0. Second pulse before clear: pend[0] stays 1 and no interrupt. Write 0x01 to IRQ_CLR: interrupt stays 0. Repeat without clearing pend: interrupt re-asserts one cycle after the IRQ_CLR write.
- mask=0x00, press dbbtns[2]: pend reads 0x02 and interrupt stays 0. Write mask=0x02: interrupt=1 next cycle.
- IRQ_CLR write of 0x08 in the same cycle as an irq_ext rising edge: pend[3] remains 1. Assert sysreset mid-interrupt: interrupt and pend go to 0 asynchronously.

Source files
------------

// File: rtl/bot_io_pkg.sv
// Address map and interrupt bit assignments shared by the Rojobot I/O hub and its IRQ controller.
package bot_io_pkg;

    typedef logic [3:0] irq_vec_t;

    localparam logic [4:0] ADDR_BTN      = 5'h00;
    localparam logic [4:0] ADDR_IRQ_PEND = 5'h01;
    localparam logic [4:0] ADDR_IRQ_MASK = 5'h02;
    localparam logic [4:0] ADDR_IRQ_CLR  = 5'h03;
    localparam logic [4:0] ADDR_MOTCTL   = 5'h04;
    localparam logic [4:0] ADDR_DP       = 5'h05;
    localparam logic [4:0] ADDR_BOT_BASE = 5'h08;
    localparam logic [4:0] ADDR_SW_BASE  = 5'h10;
    localparam logic [4:0] ADDR_LED_BASE = 5'h14;
    localparam logic [4:0] ADDR_DIG_BASE = 5'h18;

    localparam int NUM_BOT_REGS = 6;

    localparam int IRQ_UPD = 0;
    localparam int IRQ_BTN = 1;
    localparam int IRQ_SW  = 2;
    localparam int IRQ_EXT = 3;

endpackage

// File: rtl/bot_irq_ctrl.sv
// Interrupt controller: source edge detection, pending/mask registers and the
// interrupt/acknowledge handshake guarded by an in-service flag.
module bot_irq_ctrl
    import bot_io_pkg::*;
#(
    parameter int SW_W = 16
) (
    input  logic            sysclk,
    input  logic            sysreset,
    input  logic [4:0]      dbbtns,
    input  logic [SW_W-1:0] sw,
    input  logic            irq_ext,
    input  logic            upd_sysregs,
    input  logic            mask_we,
    input  irq_vec_t        mask_wdata,
    input  logic            clr_we,
    input  irq_vec_t        clr_wdata,
    input  logic            interrupt_ack,
    output irq_vec_t        pend,
    output irq_vec_t        mask,
    output logic            interrupt
);

    logic [4:0]      btn_prev_q;
    logic [SW_W-1:0] sw_prev_q;
    logic            ext_prev_q;
    irq_vec_t        pend_q, pend_d;
    irq_vec_t        mask_q, mask_d;
    irq_vec_t        evt, clr_bits;
    logic            in_service_q, in_service_d;
    logic            interrupt_q, interrupt_d;

    always_comb begin
        evt          = '0;
        evt[IRQ_UPD] = upd_sysregs;
        evt[IRQ_BTN] = |(dbbtns & ~btn_prev_q);
        evt[IRQ_SW]  = |(sw ^ sw_prev_q);
        evt[IRQ_EXT] = irq_ext & ~ext_prev_q;

        // OR-ing events in after the clear lets a same-cycle event win.
        clr_bits = clr_we ? clr_wdata : '0;
        pend_d   = (pend_q & ~clr_bits) | evt;
        mask_d   = mask_we ? mask_wdata : mask_q;

        in_service_d = in_service_q;
        if (clr_we) begin
            in_service_d = 1'b0;
        end else if (interrupt_ack) begin
            in_service_d = 1'b1;
        end

        interrupt_d = interrupt_q;
        if (interrupt_ack) begin
            interrupt_d = 1'b0;
        end else if ((|(pend_q & mask_q)) && !in_service_q) begin
            interrupt_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            btn_prev_q   <= '0;
            sw_prev_q    <= '0;
            ext_prev_q   <= 1'b0;
            pend_q       <= '0;
            mask_q       <= '0;
            in_service_q <= 1'b0;
            interrupt_q  <= 1'b0;
        end else begin
            btn_prev_q   <= dbbtns;
            sw_prev_q    <= sw;
            ext_prev_q   <= irq_ext;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign pend      = pend_q;
    assign mask      = mask_q;
    assign interrupt = interrupt_q;

endmodule

// File: rtl/bot_io_hub.sv
// KCPSM6 port-bus register hub for the Rojobot: address decode, board I/O registers,
// coherent bot-register snapshot and registered read-back.
module bot_io_hub
    import bot_io_pkg::*;
#(
    parameter int NUM_SW_BANKS  = 2,
    parameter int NUM_LED_BANKS = 2,
    parameter int NUM_DIGITS    = 8,
    parameter bit FULL_DECODE   = 1'b0
) (
    input  logic                      sysclk,
    input  logic                      sysreset,
    input  logic [7:0]                port_id,
    input  logic [7:0]                io_data_in,
    input  logic                      write_strobe,
    input  logic                      k_write_strobe,
    input  logic                      read_strobe,
    output logic [7:0]                io_data_out,
    output logic                      interrupt,
    input  logic                      interrupt_ack,
    input  logic [4:0]                dbbtns,
    input  logic [8*NUM_SW_BANKS-1:0] sw,
    input  logic                      irq_ext,
    input  logic [7:0]                locx,
    input  logic [7:0]                locy,
    input  logic [7:0]                botinfo,
    input  logic [7:0]                sensors,
    input  logic [7:0]                lmdist,
    input  logic [7:0]                rmdist,
    input  logic                      upd_sysregs,
    output logic [7:0]                MotCtl,
    output logic [8*NUM_LED_BANKS-1:0] leds,
    output logic [5*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dp
);

    localparam int SW_W  = 8 * NUM_SW_BANKS;
    localparam int LED_W = 8 * NUM_LED_BANKS;
    localparam int DIG_W = 5 * NUM_DIGITS;
    localparam int BOT_W = 8 * NUM_BOT_REGS;

    logic [4:0]            rd_addr, wr_addr;
    logic                  hit, wr_en;
    logic [7:0]            rdata_q, rdata_d;
    logic [7:0]            motctl_q, motctl_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic [LED_W-1:0]      leds_q, leds_d;
    logic [DIG_W-1:0]      digits_q, digits_d;
    logic [BOT_W-1:0]      bot_q, bot_d;
    irq_vec_t              pend, mask;
    logic                  unused_rd_strobe;

    assign unused_rd_strobe = read_strobe;

    // OUTPUTK carries only a 4-bit port, so it can never reach the upper half of the map.
    always_comb begin
        rd_addr = port_id[4:0];
        hit     = !FULL_DECODE || (port_id[7:5] == 3'b000);
        wr_en   = 1'b0;
        wr_addr = port_id[4:0];
        if (write_strobe) begin
            wr_en = hit;
        end else if (k_write_strobe) begin
            wr_en   = 1'b1;
            wr_addr = {1'b0, port_id[3:0]};
        end
    end

    always_comb begin
        motctl_d = motctl_q;
        dp_d     = dp_q;
        leds_d   = leds_q;
        digits_d = digits_q;
        bot_d    = upd_sysregs ? {rmdist, lmdist, sensors, botinfo, locy, locx} : bot_q;
        if (wr_en) begin
            if (wr_addr == ADDR_MOTCTL) motctl_d = io_data_in;
            if (wr_addr == ADDR_DP)     dp_d     = io_data_in[NUM_DIGITS-1:0];
            for (int i = 0; i < NUM_LED_BANKS; i++) begin
                if (wr_addr == ADDR_LED_BASE + 5'(i)) leds_d[8*i +: 8] = io_data_in;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_addr == ADDR_DIG_BASE + 5'(i)) digits_d[5*i +: 5] = io_data_in[4:0];
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (rd_addr)
                ADDR_BTN:      rdata_d = {3'b000, dbbtns};
                ADDR_IRQ_PEND: rdata_d = {4'h0, pend};
                ADDR_IRQ_MASK: rdata_d = {4'h0, mask};
                ADDR_MOTCTL:   rdata_d = motctl_q;
                ADDR_DP:       rdata_d[NUM_DIGITS-1:0] = dp_q;
                default:       ;
            endcase
            for (int j = 0; j < NUM_BOT_REGS; j++) begin
                if (rd_addr == ADDR_BOT_BASE + 5'(j)) rdata_d = bot_q[8*j +: 8];
            end
            for (int i = 0; i < NUM_SW_BANKS; i++) begin
                if (rd_addr == ADDR_SW_BASE + 5'(i)) rdata_d = sw[8*i +: 8];
            end
            for (int i = 0; i < NUM_LED_BANKS; i++) begin
                if (rd_addr == ADDR_LED_BASE + 5'(i)) rdata_d = leds_q[8*i +: 8];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (rd_addr == ADDR_DIG_BASE + 5'(i)) rdata_d = {3'b000, digits_q[5*i +: 5]};
            end
        end
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            rdata_q  <= '0;
            motctl_q <= '0;
            dp_q     <= '0;
            leds_q   <= '0;
            digits_q <= '0;
            bot_q    <= '0;
        end else begin
            rdata_q  <= rdata_d;
            motctl_q <= motctl_d;
            dp_q     <= dp_d;
            leds_q   <= leds_d;
            digits_q <= digits_d;
            bot_q    <= bot_d;
        end
    end

    bot_irq_ctrl #(
        .SW_W (SW_W)
    ) u_irq (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .dbbtns        (dbbtns),
        .sw            (sw),
        .irq_ext       (irq_ext),
        .upd_sysregs   (upd_sysregs),
        .mask_we       (wr_en && (wr_addr == ADDR_IRQ_MASK)),
        .mask_wdata    (io_data_in[3:0]),
        .clr_we        (wr_en && (wr_addr == ADDR_IRQ_CLR)),
        .clr_wdata     (io_data_in[3:0]),
        .interrupt_ack (interrupt_ack),
        .pend          (pend),
        .mask          (mask),
        .interrupt     (interrupt)
    );

    assign io_data_out = rdata_q;
    assign MotCtl      = motctl_q;
    assign leds        = leds_q;
    assign digits      = digits_q;
    assign dp          = dp_q;

endmodule
